// File: rtl/dcache_pkg.sv
// dcache_pkg: shared constants, FSM state type and address field helpers for the data cache
package dcache_pkg;
  localparam int OFF_W = 5;
  localparam int WORD_SEL_W = 3;
  typedef enum logic [1:0] {IDLE, WRBACK, ALLOC, REFILL} state_e;
  function automatic logic [31:0] addr_tag(input logic [31:0] a, input int idx_w);
    return a >> (OFF_W + idx_w);
  endfunction
  function automatic logic [31:0] addr_idx(input logic [31:0] a, input int idx_w);
    return (a >> OFF_W) & ((32'd1 << idx_w) - 32'd1);
  endfunction
  function automatic logic [WORD_SEL_W-1:0] addr_word(input logic [31:0] a);
    return a[4:2];
  endfunction
endpackage

// File: rtl/dcache_array.sv
// dcache_array: tag/valid/dirty/data storage, one combinational read port, one sync write port
//   i_clk, i_rst_n           clock, async active-low reset (clears valid and dirty only)
//   i_rd_idx                 read index; o_valid/o_dirty/o_tag/o_data follow it combinationally
//   i_wr_idx                 write index shared by both write kinds
//   i_line_we/_tag/_data     full-line fill: sets tag, valid=1, dirty=0
//   i_word_we/_sel/_data     single-word store: sets dirty=1
module dcache_array #(
  parameter int NUM_LINES = 32,
  parameter int LINE_W = 256,
  parameter int IDX_W = 5,
  parameter int TAG_W = 22
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic              o_valid,
  output logic              o_dirty,
  output logic [TAG_W-1:0]  o_tag,
  output logic [LINE_W-1:0] o_data,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic              i_line_we,
  input  logic [TAG_W-1:0]  i_line_tag,
  input  logic [LINE_W-1:0] i_line_data,
  input  logic              i_word_we,
  input  logic [2:0]        i_word_sel,
  input  logic [31:0]       i_word_data
);
  logic [NUM_LINES-1:0] r_valid;
  logic [NUM_LINES-1:0] r_dirty;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [LINE_W-1:0]    r_data [NUM_LINES];
  assign o_valid = r_valid[i_rd_idx];
  assign o_dirty = r_dirty[i_rd_idx];
  assign o_tag   = r_tag[i_rd_idx];
  assign o_data  = r_data[i_rd_idx];
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_line_we) begin
      r_valid[i_wr_idx] <= 1'b1;
      r_dirty[i_wr_idx] <= 1'b0;
    end else if (i_word_we) begin
      r_dirty[i_wr_idx] <= 1'b1;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_line_we) begin
      r_tag[i_wr_idx]  <= i_line_tag;
      r_data[i_wr_idx] <= i_line_data;
    end else if (i_word_we) begin
      r_data[i_wr_idx][{i_word_sel, 5'b0} +: 32] <= i_word_data;
    end
  end
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back write-allocate data cache controller with MEM-stage stall
//   clk_i, rst_i                 clock, async active-low reset
//   cpu_req_i/we_i/addr_i/wdata_i  MEM-stage load/store request
//   cpu_rdata_o, mem_stall_o     load data (valid on hit), pipeline freeze
//   mem_req_o/we_o/addr_o/wdata_o  registered line request to memory (write-back or fetch)
//   mem_ack_i, mem_rdata_i       one-cycle completion pulse and fetched line
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              mem_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [LINE_W-1:0] mem_rdata_i
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 32 - IDX_W - OFF_W;
  state_e r_state, w_next;
  logic [31:0]       r_addr;
  logic              r_mem_req, r_mem_we;
  logic [31:0]       r_mem_addr;
  logic [LINE_W-1:0] r_mem_wdata;
  logic [IDX_W-1:0]  w_idx, w_r_idx;
  logic [TAG_W-1:0]  w_tag, w_r_tag, w_rd_tag;
  logic [2:0]        w_word;
  logic              w_valid, w_dirty, w_hit, w_miss, w_line_we, w_word_we;
  logic [LINE_W-1:0] w_data;
  assign w_idx   = IDX_W'(addr_idx(cpu_addr_i, IDX_W));
  assign w_tag   = TAG_W'(addr_tag(cpu_addr_i, IDX_W));
  assign w_word  = addr_word(cpu_addr_i);
  assign w_r_idx = IDX_W'(addr_idx(r_addr, IDX_W));
  assign w_r_tag = TAG_W'(addr_tag(r_addr, IDX_W));
  assign w_hit   = cpu_req_i & w_valid & (w_rd_tag == w_tag);
  assign w_miss  = cpu_req_i & ~w_hit;
  // Gated by reset so the pipeline is released the instant reset is applied.
  assign mem_stall_o = rst_i & cpu_req_i & ~(w_hit & (r_state == IDLE));
  assign cpu_rdata_o = w_data[{w_word, 5'b0} +: 32];
  assign w_line_we = (r_state == ALLOC) & mem_ack_i;
  assign w_word_we = (r_state == IDLE) & w_hit & cpu_we_i;
  assign mem_req_o   = r_mem_req;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  dcache_array #(.NUM_LINES(NUM_LINES), .LINE_W(LINE_W), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_array (
    .i_clk(clk_i),
    .i_rst_n(rst_i),
    .i_rd_idx(w_idx),
    .o_valid(w_valid),
    .o_dirty(w_dirty),
    .o_tag(w_rd_tag),
    .o_data(w_data),
    .i_wr_idx(w_line_we ? w_r_idx : w_idx),
    .i_line_we(w_line_we),
    .i_line_tag(w_r_tag),
    .i_line_data(mem_rdata_i),
    .i_word_we(w_word_we),
    .i_word_sel(w_word),
    .i_word_data(cpu_wdata_i)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_miss ? ((w_valid & w_dirty) ? WRBACK : ALLOC) : IDLE;
      WRBACK:  w_next = mem_ack_i ? ALLOC : WRBACK;
      ALLOC:   w_next = mem_ack_i ? REFILL : ALLOC;
      default: w_next = IDLE;
    endcase
  end
  // Memory request is held across WRBACK->ALLOC; only we/addr change after the write-back ack.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_miss) begin
        r_addr      <= cpu_addr_i;
        r_mem_req   <= 1'b1;
        r_mem_we    <= w_valid & w_dirty;
        r_mem_addr  <= (w_valid & w_dirty) ? {w_rd_tag, w_idx, {OFF_W{1'b0}}} : {cpu_addr_i[31:OFF_W], {OFF_W{1'b0}}};
        r_mem_wdata <= w_data;
      end else if (r_state == WRBACK && mem_ack_i) begin
        r_mem_we   <= 1'b0;
        r_mem_addr <= {r_addr[31:OFF_W], {OFF_W{1'b0}}};
      end else if (r_state == ALLOC && mem_ack_i) begin
        r_mem_req <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: scoreboard bench for dcache_ctrl with a latency-programmable line memory model
module tb_dcache_ctrl;
  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_i = 1'b0, cpu_we_i = 1'b0;
  logic [31:0]  cpu_addr_i = '0, cpu_wdata_i = '0;
  logic [31:0]  cpu_rdata_o;
  logic         mem_stall_o, mem_req_o, mem_we_o, mem_ack_i;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_wdata_o, mem_rdata_i;
  logic         model_ack = 1'b0, force_ack = 1'b0;
  logic [255:0] model_rdata = '0;
  int checks = 0, errors = 0, lat = 4, cnt = 0;
  typedef struct { logic we; logic [31:0] addr; logic [255:0] wdata; } tx_t;
  typedef struct { logic [31:0] rdata; int stalls; bit is_load; string nm; } exp_t;
  tx_t txlog[$];
  exp_t sb[$];
  logic [255:0] mem [logic [31:0]];
  logic cap_we;
  logic [31:0] cap_addr;
  logic [255:0] cap_wdata;

  assign mem_ack_i = model_ack | force_ack;
  assign mem_rdata_i = model_rdata;
  always #5 clk_i = ~clk_i;

  dcache_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
    .cpu_rdata_o(cpu_rdata_o), .mem_stall_o(mem_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'hC0DE_0000;
  endfunction
  function automatic logic [255:0] mem_line(input logic [31:0] a);
    logic [255:0] l;
    if (mem.exists(a)) return mem[a];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = pat(a + 32'(w * 4));
    return l;
  endfunction
  function automatic int clean(input int k); return k + 2; endfunction
  function automatic int dirty(input int k); return 2 * k + 2; endfunction

  // Memory: acks in the lat-th cycle of a held request; a request still high after an ack is a new one.
  always @(negedge clk_i) begin
    model_ack = 1'b0;
    if (!rst_i || !mem_req_o) cnt = 0;
    else begin
      cnt++;
      if (cnt == 1) begin
        cap_we = mem_we_o; cap_addr = mem_addr_o; cap_wdata = mem_wdata_o;
      end else begin
        checks++;
        if ({mem_we_o, mem_addr_o, mem_wdata_o} !== {cap_we, cap_addr, cap_wdata}) begin
          errors++;
          $display("FAIL req_stable: we=%0b addr=%h while waiting, required we=%0b addr=%h held", mem_we_o, mem_addr_o, cap_we, cap_addr);
        end
      end
      if (cnt >= lat) begin
        model_ack = 1'b1;
        cnt = 0;
        if (mem_we_o) mem[mem_addr_o] = mem_wdata_o;
        else model_rdata = mem_line(mem_addr_o);
        txlog.push_back('{mem_we_o, mem_addr_o, mem_wdata_o});
      end
    end
  end

  task automatic access(input string nm, input bit we, input logic [31:0] a, input logic [31:0] d,
                        input int exp_st, input logic [31:0] exp_rd);
    exp_t e;
    int st = 0;
    sb.push_back('{exp_rd, exp_st, !we, nm});
    cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = a; cpu_wdata_i = d;
    forever begin
      @(negedge clk_i);
      if (!mem_stall_o) break;
      st++;
      if (st > 200) begin
        checks++; errors++;
        $display("FAIL %s_timeout: stall still high after %0d cycles, required release", nm, st);
        break;
      end
    end
    e = sb.pop_front();
    checks++;
    if (st !== e.stalls) begin
      errors++;
      $display("FAIL %s_stalls: got %0d, required %0d", e.nm, st, e.stalls);
    end
    if (e.is_load) begin
      checks++;
      if (cpu_rdata_o !== e.rdata) begin
        errors++;
        $display("FAIL %s_rdata: got %h, required %h", e.nm, cpu_rdata_o, e.rdata);
      end
    end
    @(posedge clk_i); #1;
    cpu_req_i = 1'b0; cpu_we_i = 1'b0;
  endtask

  task automatic check_tx(input string nm, input int i, input logic we, input logic [31:0] a);
    checks++;
    if (txlog.size() <= i) begin
      errors++;
      $display("FAIL %s: only %0d memory transactions, required entry %0d", nm, txlog.size(), i);
    end else if (txlog[i].we !== we || txlog[i].addr !== a) begin
      errors++;
      $display("FAIL %s: got we=%0b addr=%h, required we=%0b addr=%h", nm, txlog[i].we, txlog[i].addr, we, a);
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if ({mem_req_o, mem_we_o, mem_stall_o, mem_addr_o, mem_wdata_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: req=%0b we=%0b stall=%0b addr=%h, required all zero", mem_req_o, mem_we_o, mem_stall_o, mem_addr_o);
    end
    @(negedge clk_i); rst_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_clean_miss;
    lat = 4; txlog.delete();
    access("clean_miss", 0, 32'h40, 0, clean(lat), pat(32'h40));
    checks++;
    if (txlog.size() != 1) begin
      errors++;
      $display("FAIL clean_miss_txcount: got %0d, required 1", txlog.size());
    end
    check_tx("clean_miss_fetch", 0, 1'b0, 32'h40);
    access("reload_hit", 0, 32'h40, 0, 0, pat(32'h40));
    access("other_word_hit", 0, 32'h5C, 0, 0, pat(32'h5C));
  endtask

  task automatic test_store_hit;
    txlog.delete();
    access("store_hit", 1, 32'h44, 32'hDEAD_BEEF, 0, 0);
    checks++;
    if (txlog.size() != 0) begin
      errors++;
      $display("FAIL store_hit_traffic: got %0d transactions, required 0", txlog.size());
    end
    access("store_readback", 0, 32'h44, 0, 0, 32'hDEAD_BEEF);
  endtask

  task automatic test_dirty_evict;
    txlog.delete();
    access("dirty_miss", 0, 32'h440, 0, dirty(lat), pat(32'h440));
    check_tx("evict_wb", 0, 1'b1, 32'h40);
    check_tx("evict_fetch", 1, 1'b0, 32'h440);
    checks++;
    if (txlog.size() < 1 || txlog[0].wdata[63:0] !== {32'hDEAD_BEEF, pat(32'h40)}) begin
      errors++;
      $display("FAIL evict_wdata: got %h, required %h", txlog.size() ? txlog[0].wdata[63:0] : 64'h0, {32'hDEAD_BEEF, pat(32'h40)});
    end
  endtask

  task automatic test_latency;
    lat = 1; txlog.delete();
    access("fast_clean_store", 1, 32'h40, 32'h1111_2222, clean(lat), 0);
    access("fast_dirty_load", 0, 32'h840, 0, dirty(lat), pat(32'h840));
    check_tx("fast_wb", 1, 1'b1, 32'h40);
    checks++;
    if (txlog.size() < 2 || txlog[1].wdata[31:0] !== 32'h1111_2222) begin
      errors++;
      $display("FAIL fast_wb_data: got %h, required %h", txlog.size() > 1 ? txlog[1].wdata[31:0] : 32'h0, 32'h1111_2222);
    end
    lat = 20;
    access("slow_clean_store", 1, 32'h48, 32'h3333_4444, clean(lat), 0);
    access("slow_dirty_load", 0, 32'h448, 0, dirty(lat), pat(32'h448));
    access("slow_refetch", 0, 32'h48, 0, clean(lat), 32'h3333_4444);
    access("slow_same_line", 0, 32'h40, 0, 0, 32'h1111_2222);
    lat = 4;
  endtask

  task automatic test_reset_wrback;
    int n = 0;
    access("rst_setup_store", 1, 32'h60, 32'h5555_6666, clean(lat), 0);
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h460;
    do begin
      @(negedge clk_i);
      n++;
    end while (!(mem_req_o && mem_we_o) && n < 20);
    checks++;
    if (!(mem_req_o && mem_we_o)) begin
      errors++;
      $display("FAIL rst_wrback_reach: req=%0b we=%0b, required write-back in progress", mem_req_o, mem_we_o);
    end
    #2 rst_i = 1'b0;
    #1;
    checks++;
    if (mem_req_o !== 1'b0 || mem_stall_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_wrback_abort: req=%0b stall=%0b, required 0 0", mem_req_o, mem_stall_o);
    end
    @(negedge clk_i);
    rst_i = 1'b1; cpu_req_i = 1'b0;
    @(posedge clk_i); #1;
    access("rst_clean_miss", 0, 32'h60, 0, clean(lat), pat(32'h60));
  endtask

  task automatic test_idle_quiet;
    for (int c = 0; c < 10; c++) begin
      force_ack = (c == 3);
      @(negedge clk_i);
      checks++;
      if (mem_stall_o !== 1'b0 || mem_req_o !== 1'b0) begin
        errors++;
        $display("FAIL idle_quiet_%0d: stall=%0b req=%0b, required 0 0", c, mem_stall_o, mem_req_o);
      end
      @(posedge clk_i); #1;
    end
    force_ack = 1'b0;
    access("idle_then_hit", 0, 32'h60, 0, 0, pat(32'h60));
  endtask

  initial begin
    test_reset;
    test_clean_miss;
    test_store_hit;
    test_dirty_evict;
    test_latency;
    test_reset_wrback;
    test_idle_quiet;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
